// File: rtl/lcd_hd44780_responder.sv
// HD44780-compatible responder for a 4-bit LCD bus: follows the power-on nibble sequence,
// reassembles bytes, decodes commands, keeps a 2x16 DDRAM image and busy timing, flags bus misuse.
module lcd_hd44780_responder #(
    parameter int MIN_E_HIGH   = 12,
    parameter int BUSY_CYCLES  = 2000,
    parameter int CLEAR_CYCLES = 82000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iLCD_E,
    input  logic       iLCD_RS,
    input  logic       iLCD_RW,
    input  logic [3:0] iLCD_Data,
    input  logic [4:0] iRdAddr,
    output logic [7:0] oRdData,
    output logic       oByteValid,
    output logic [7:0] oByte,
    output logic       oByteIsData,
    output logic       oBusy,
    output logic       oFourBitMode,
    output logic       oDisplayOn,
    output logic       oEntryInc,
    output logic [4:0] oCursor,
    output logic       oProtocolError
);

    localparam int BUSY_MAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int BUSY_W   = $clog2(BUSY_MAX + 1);
    localparam int WIDTH_W  = $clog2(MIN_E_HIGH + 1);

    typedef enum logic [1:0] {
        ST_POR,
        ST_HI,
        ST_LO
    } state_t;

    state_t              state_q, state_d;
    logic                re_q;
    logic [WIDTH_W-1:0]  width_q, width_d;
    logic [3:0]          hi_nib_q, hi_nib_d;
    logic                hi_rs_q, hi_rs_d;
    logic [BUSY_W-1:0]   busy_cnt_q, busy_cnt_d;
    logic                byte_valid_q, byte_valid_d;
    logic [7:0]          byte_q, byte_d;
    logic                byte_is_data_q, byte_is_data_d;
    logic                four_bit_q, four_bit_d;
    logic                display_on_q, display_on_d;
    logic                entry_inc_q, entry_inc_d;
    logic [4:0]          cursor_q, cursor_d;
    logic                err_q, err_d;
    logic [7:0]          ddram_q [32];
    logic [7:0]          ddram_d [32];

    logic       fall, strobe_wr, strobe_ok, strobe_bad;
    logic       init_en, exec_en, seq_err;
    logic [7:0] exec_byte;

    // A falling edge of E is a strobe; only writes count, and they must be wide enough and not busy.
    assign fall       = re_q & ~iLCD_E;
    assign strobe_wr  = fall & ~iLCD_RW;
    assign strobe_ok  = strobe_wr && (width_q == WIDTH_W'(MIN_E_HIGH)) && (busy_cnt_q == '0);
    assign strobe_bad = strobe_wr & ~strobe_ok;
    assign exec_byte  = {hi_nib_q, iLCD_Data};

    // NOTE: the DDRAM must start as spaces and be wiped in one cycle, so it is built from
    // resettable flops rather than an inferred RAM, which could not be reset or bulk-cleared.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q        <= ST_POR;
            re_q           <= 1'b0;
            width_q        <= '0;
            hi_nib_q       <= '0;
            hi_rs_q        <= 1'b0;
            busy_cnt_q     <= '0;
            byte_valid_q   <= 1'b0;
            byte_q         <= '0;
            byte_is_data_q <= 1'b0;
            four_bit_q     <= 1'b0;
            display_on_q   <= 1'b0;
            entry_inc_q    <= 1'b1;
            cursor_q       <= '0;
            err_q          <= 1'b0;
            for (int i = 0; i < 32; i++) ddram_q[i] <= 8'h20;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
            state_q        <= state_d;
            re_q           <= iLCD_E;
            width_q        <= width_d;
            hi_nib_q       <= hi_nib_d;
            hi_rs_q        <= hi_rs_d;
            busy_cnt_q     <= busy_cnt_d;
            byte_valid_q   <= byte_valid_d;
            byte_q         <= byte_d;
            byte_is_data_q <= byte_is_data_d;
            four_bit_q     <= four_bit_d;
            display_on_q   <= display_on_d;
            entry_inc_q    <= entry_inc_d;
            cursor_q       <= cursor_d;
            err_q          <= err_d;
            ddram_q        <= ddram_d;
        end
    end

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        state_d = state_q;
        init_en = 1'b0;
        exec_en = 1'b0;
        seq_err = 1'b0;
        if (strobe_ok) begin
            case (state_q)
                ST_POR: begin
                    if (!iLCD_RS && iLCD_Data == 4'h3) begin
                        init_en = 1'b1;
                    end else if (!iLCD_RS && iLCD_Data == 4'h2) begin
                        init_en = 1'b1;
                        state_d = ST_HI;
                    end else begin
                        seq_err = 1'b1;
                    end
                end
                ST_HI: state_d = ST_LO;
                ST_LO: begin
                    if (iLCD_RS != hi_rs_q) begin
                        seq_err = 1'b1;
                        state_d = ST_HI;
                    end else begin
                        exec_en = 1'b1;
                        // Function set with DL=1 drops the bus back to 8-bit power-on handling.
                        state_d = (!iLCD_RS && exec_byte[7:4] == 4'b0011) ? ST_POR : ST_HI;
                    end
                end
                default: state_d = ST_POR;
            endcase
        end
    end

    always_comb begin
        width_d        = iLCD_E ? ((width_q == WIDTH_W'(MIN_E_HIGH)) ? width_q : width_q + WIDTH_W'(1)) : '0;
        hi_nib_d       = hi_nib_q;
        hi_rs_d        = hi_rs_q;
        busy_cnt_d     = (busy_cnt_q == '0) ? '0 : busy_cnt_q - BUSY_W'(1);
        byte_valid_d   = 1'b0;
        byte_d         = byte_q;
        byte_is_data_d = byte_is_data_q;
        four_bit_d     = four_bit_q;
        display_on_d   = display_on_q;
        entry_inc_d    = entry_inc_q;
        cursor_d       = cursor_q;
        err_d          = strobe_bad | seq_err;
        ddram_d        = ddram_q;

        if (strobe_ok && state_q == ST_HI) begin
            hi_nib_d = iLCD_Data;
            hi_rs_d  = iLCD_RS;
        end

        if (init_en) begin
            byte_valid_d   = 1'b1;
            byte_d         = {iLCD_Data, 4'h0};
            byte_is_data_d = 1'b0;
            busy_cnt_d     = BUSY_W'(BUSY_CYCLES);
            if (iLCD_Data == 4'h2) four_bit_d = 1'b1;
        end

        if (exec_en) begin
            byte_valid_d   = 1'b1;
            byte_d         = exec_byte;
            byte_is_data_d = iLCD_RS;
            busy_cnt_d     = BUSY_W'(BUSY_CYCLES);
            if (iLCD_RS) begin
                ddram_d[cursor_q] = exec_byte;
                cursor_d = entry_inc_q ? cursor_q + 5'd1 : cursor_q - 5'd1;
            end else if (exec_byte[7]) begin
                if (exec_byte[6:4] == 3'b000)      cursor_d = {1'b0, exec_byte[3:0]};
                else if (exec_byte[6:4] == 3'b100) cursor_d = {1'b1, exec_byte[3:0]};
                else                               err_d    = 1'b1;
            end else if (exec_byte[6]) begin
                cursor_d = cursor_q;
            end else if (exec_byte[5]) begin
                if (exec_byte[4]) four_bit_d = 1'b0;
            end else if (exec_byte[4]) begin
                if (!exec_byte[3]) cursor_d = exec_byte[2] ? cursor_q + 5'd1 : cursor_q - 5'd1;
            end else if (exec_byte[3]) begin
                display_on_d = exec_byte[2];
            end else if (exec_byte[2]) begin
                entry_inc_d = exec_byte[1];
            end else if (exec_byte[1]) begin
                cursor_d   = '0;
                busy_cnt_d = BUSY_W'(CLEAR_CYCLES);
            end else if (exec_byte[0]) begin
                for (int i = 0; i < 32; i++) ddram_d[i] = 8'h20;
                cursor_d    = '0;
                entry_inc_d = 1'b1;
                busy_cnt_d  = BUSY_W'(CLEAR_CYCLES);
            end
        end
    end

    assign oRdData        = ddram_q[iRdAddr];
    assign oByteValid     = byte_valid_q;
    assign oByte          = byte_q;
    assign oByteIsData    = byte_is_data_q;
    assign oBusy          = (busy_cnt_q != '0);
    assign oFourBitMode   = four_bit_q;
    assign oDisplayOn     = display_on_q;
    assign oEntryInc      = entry_inc_q;
    assign oCursor        = cursor_q;
    assign oProtocolError = err_q;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Directed bench for lcd_hd44780_responder: init sequence, command/data decode, DDRAM wrap,
// protocol errors and mid-byte reset, with busy times shortened through the parameters.
module tb_lcd_hd44780_responder;

    localparam int MIN_E = 12;
    localparam int BUSY  = 40;
    localparam int CLR   = 300;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       e, rs, rw;
    logic [3:0] data;
    logic [4:0] rd_addr;
    logic [7:0] oRdData, oByte;
    logic       oByteValid, oByteIsData, oBusy, oFourBitMode, oDisplayOn, oEntryInc, oProtocolError;
    logic [4:0] oCursor;

    int   n_assert = 0;
    int   n_fail   = 0;
    logic obs_valid, obs_err;
    int   busy_len;
    logic [7:0] ram_val;

    lcd_hd44780_responder #(
        .MIN_E_HIGH  (MIN_E),
        .BUSY_CYCLES (BUSY),
        .CLEAR_CYCLES(CLR)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .iLCD_E        (e),
        .iLCD_RS       (rs),
        .iLCD_RW       (rw),
        .iLCD_Data     (data),
        .iRdAddr       (rd_addr),
        .oRdData       (oRdData),
        .oByteValid    (oByteValid),
        .oByte         (oByte),
        .oByteIsData   (oByteIsData),
        .oBusy         (oBusy),
        .oFourBitMode  (oFourBitMode),
        .oDisplayOn    (oDisplayOn),
        .oEntryInc     (oEntryInc),
        .oCursor       (oCursor),
        .oProtocolError(oProtocolError)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One E pulse of 'hi' high cycles; captures the pulse outputs in the cycle after the fall.
    task automatic strobe(input logic s_rs, input logic s_rw, input logic [3:0] nib, input int hi);
        @(negedge Clock);
        rs = s_rs; rw = s_rw; data = nib; e = 1'b1;
        repeat (hi) @(negedge Clock);
        e = 1'b0;
        @(negedge Clock);
        obs_valid = oByteValid;
        obs_err   = oProtocolError;
    endtask

    task automatic send_byte(input logic s_rs, input logic [7:0] b);
        strobe(s_rs, 1'b0, b[7:4], MIN_E + 1);
        check("hi nibble silent", {30'd0, obs_valid, obs_err}, 32'd0);
        strobe(s_rs, 1'b0, b[3:0], MIN_E + 1);
    endtask

    // Counts cycles with oBusy high from the current sample point; bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (oBusy && n < 2 * CLR) begin
            n++;
            @(negedge Clock);
        end
        check("busy timeout", {31'd0, oBusy}, 32'd0);
    endtask

    task automatic read_ram(input logic [4:0] a, output logic [7:0] d);
        rd_addr = a;
        #1;
        d = oRdData;
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b1; e = 1'b0;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
    endtask

    task automatic do_init();
        for (int i = 0; i < 3; i++) begin
            strobe(1'b0, 1'b0, 4'h3, MIN_E + 1);
            check("init3 valid", {30'd0, obs_valid, obs_err}, 32'd2);
            check("init3 byte", {24'd0, oByte}, 32'h30);
            wait_idle(busy_len);
            check("init3 busy len", busy_len, BUSY);
            check("init3 still 8-bit", {31'd0, oFourBitMode}, 32'd0);
        end
        strobe(1'b0, 1'b0, 4'h2, MIN_E + 1);
        check("init2 valid", {30'd0, obs_valid, obs_err}, 32'd2);
        check("init2 byte", {24'd0, oByte}, 32'h20);
        check("init2 four-bit", {31'd0, oFourBitMode}, 32'd1);
        wait_idle(busy_len);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; e = 1'b0; rs = 1'b0; rw = 1'b0; data = 4'h0; rd_addr = 5'd0;
        do_reset();

        // Reset state
        check("rst outputs", {24'd0, oByteValid, oByteIsData, oBusy, oFourBitMode, oDisplayOn, oEntryInc, oProtocolError, 1'b0}, 32'h04);
        check("rst byte", {24'd0, oByte}, 32'h00);
        check("rst cursor", {27'd0, oCursor}, 32'd0);
        read_ram(5'd0, ram_val);  check("rst ram0", {24'd0, ram_val}, 32'h20);
        read_ram(5'd31, ram_val); check("rst ram31", {24'd0, ram_val}, 32'h20);

        do_init();

        // Configuration bytes
        send_byte(1'b0, 8'h28);
        check("0x28 valid", {30'd0, obs_valid, obs_err}, 32'd2);
        check("0x28 byte", {23'd0, oByteIsData, oByte}, 32'h028);
        check("0x28 stays 4-bit", {31'd0, oFourBitMode}, 32'd1);
        wait_idle(busy_len);
        send_byte(1'b0, 8'h06);
        check("0x06 entry inc", {31'd0, oEntryInc}, 32'd1);
        wait_idle(busy_len);
        send_byte(1'b0, 8'h0C);
        check("0x0C display on", {31'd0, oDisplayOn}, 32'd1);
        wait_idle(busy_len);
        check("0x0C busy len", busy_len, BUSY);
        send_byte(1'b0, 8'h01);
        check("clear valid", {30'd0, obs_valid, obs_err}, 32'd2);
        wait_idle(busy_len);
        check("clear busy len", busy_len, CLR);

        // Data write and line-2 addressing with wrap
        send_byte(1'b1, 8'h41);
        check("data41 byte", {23'd0, oByteIsData, oByte}, 32'h141);
        read_ram(5'd0, ram_val); check("data41 ram0", {24'd0, ram_val}, 32'h41);
        check("data41 cursor", {27'd0, oCursor}, 32'd1);
        wait_idle(busy_len);
        send_byte(1'b0, 8'hCF);
        check("0xCF cursor", {27'd0, oCursor}, 32'd31);
        wait_idle(busy_len);
        send_byte(1'b1, 8'h42);
        check("data42 cursor wrap", {27'd0, oCursor}, 32'd0);
        wait_idle(busy_len);
        send_byte(1'b1, 8'h43);
        read_ram(5'd31, ram_val); check("ram31", {24'd0, ram_val}, 32'h42);
        read_ram(5'd0, ram_val);  check("ram0 wrap", {24'd0, ram_val}, 32'h43);
        check("data43 cursor", {27'd0, oCursor}, 32'd1);

        // Protocol errors: strobe while busy, short E, RW=1 ignored, bad DDRAM address
        strobe(1'b1, 1'b0, 4'h4, MIN_E + 1);
        check("busy strobe err", {30'd0, obs_valid, obs_err}, 32'd1);
        wait_idle(busy_len);
        strobe(1'b0, 1'b0, 4'h8, 5);
        check("short E err", {30'd0, obs_valid, obs_err}, 32'd1);
        strobe(1'b0, 1'b1, 4'h8, MIN_E + 1);
        check("RW=1 ignored", {30'd0, obs_valid, obs_err}, 32'd0);
        send_byte(1'b0, 8'h90);
        check("0x90 valid+err", {30'd0, obs_valid, obs_err}, 32'd3);
        check("0x90 byte", {24'd0, oByte}, 32'h90);
        check("0x90 cursor kept", {27'd0, oCursor}, 32'd1);
        wait_idle(busy_len);

        // RS mismatch between nibbles
        strobe(1'b0, 1'b0, 4'h1, MIN_E + 1);
        check("mismatch hi silent", {30'd0, obs_valid, obs_err}, 32'd0);
        strobe(1'b1, 1'b0, 4'h4, MIN_E + 1);
        check("RS mismatch err", {30'd0, obs_valid, obs_err}, 32'd1);

        // Cursor shift, display shift, CGRAM, home
        send_byte(1'b0, 8'h14);
        check("shift right", {27'd0, oCursor}, 32'd2);
        wait_idle(busy_len);
        send_byte(1'b0, 8'h10);
        check("shift left", {27'd0, oCursor}, 32'd1);
        wait_idle(busy_len);
        send_byte(1'b0, 8'h18);
        check("display shift keeps cursor", {27'd0, oCursor}, 32'd1);
        wait_idle(busy_len);
        send_byte(1'b0, 8'h40);
        check("CGRAM accepted", {30'd0, obs_valid, obs_err}, 32'd2);
        check("CGRAM cursor kept", {27'd0, oCursor}, 32'd1);
        wait_idle(busy_len);
        send_byte(1'b0, 8'h08);
        check("display off", {31'd0, oDisplayOn}, 32'd0);
        wait_idle(busy_len);
        send_byte(1'b0, 8'h02);
        check("home cursor", {27'd0, oCursor}, 32'd0);
        wait_idle(busy_len);
        check("home busy len", busy_len, CLR);

        // Reset after the high nibble of 0x41, then re-init
        strobe(1'b1, 1'b0, 4'h4, MIN_E + 1);
        do_reset();
        check("mid reset 8-bit", {31'd0, oFourBitMode}, 32'd0);
        check("mid reset cursor", {27'd0, oCursor}, 32'd0);
        read_ram(5'd0, ram_val); check("mid reset ram0", {24'd0, ram_val}, 32'h20);
        do_init();
        send_byte(1'b1, 8'h58);
        check("0x58 byte", {23'd0, oByteIsData, oByte}, 32'h158);
        read_ram(5'd0, ram_val); check("0x58 ram0", {24'd0, ram_val}, 32'h58);
        check("0x58 cursor", {27'd0, oCursor}, 32'd1);
        wait_idle(busy_len);

        // Decrementing entry, then clear restores spaces and increment mode
        send_byte(1'b0, 8'h04);
        check("entry dec", {31'd0, oEntryInc}, 32'd0);
        wait_idle(busy_len);
        send_byte(1'b1, 8'h59);
        check("dec cursor", {27'd0, oCursor}, 32'd0);
        read_ram(5'd1, ram_val); check("ram1", {24'd0, ram_val}, 32'h59);
        wait_idle(busy_len);
        send_byte(1'b0, 8'h01);
        read_ram(5'd0, ram_val); check("clear ram0", {24'd0, ram_val}, 32'h20);
        read_ram(5'd1, ram_val); check("clear ram1", {24'd0, ram_val}, 32'h20);
        check("clear entry inc", {31'd0, oEntryInc}, 32'd1);
        wait_idle(busy_len);

        // Function set DL=1 returns to 8-bit power-on handling
        send_byte(1'b0, 8'h30);
        check("DL=1 valid", {30'd0, obs_valid, obs_err}, 32'd2);
        check("DL=1 8-bit", {31'd0, oFourBitMode}, 32'd0);
        wait_idle(busy_len);
        strobe(1'b0, 1'b0, 4'h3, MIN_E + 1);
        check("8-bit nibble3", {30'd0, obs_valid, obs_err}, 32'd2);
        wait_idle(busy_len);
        strobe(1'b0, 1'b0, 4'h5, MIN_E + 1);
        check("POR bad nibble", {30'd0, obs_valid, obs_err}, 32'd1);
        strobe(1'b1, 1'b0, 4'h3, MIN_E + 1);
        check("POR RS=1", {30'd0, obs_valid, obs_err}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
